// File: rtl/vedic_4x4_multiplier.sv
// Registered 4x4 unsigned multiplier from four 2x2 Vedic cells.
// Ports: clk, rst (async, active-high), ena (hold when low),
//   ui_in[3:0]=a, ui_in[7:4]=b, uio_in ignored,
//   uo_out = registered a*b, uio_out/uio_oe = status nibble.
// Optional status nibble enabled by defining VEDIC_STATUS_EN.
module vedic_4x4_multiplier (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    // 2x2 Urdhva-Tiryagbhyam cell: vertical AND, crosswise half adder,
    // then a second half adder folds the crosswise carry into the top.
    function automatic logic [3:0] vedic2(
        input logic [1:0] x,
        input logic [1:0] y
    );
        logic p0, c0, c1, hi;
        logic s1, k1;
        p0 = x[0] & y[0];
        c0 = x[1] & y[0];
        c1 = x[0] & y[1];
        hi = x[1] & y[1];
        s1 = c0 ^ c1;
        k1 = c0 & c1;
        return {hi & k1, hi ^ k1, s1, p0};
    endfunction

    logic [3:0] a, b;
    logic [3:0] q0, q1, q2, q3;
    logic [4:0] mid;
    logic [5:0] upper;
    logic [7:0] prod_d;
    logic [7:0] prod_q;

    assign a = ui_in[3:0];
    assign b = ui_in[7:4];

    assign q0 = vedic2(a[1:0], b[1:0]);
    assign q1 = vedic2(a[3:2], b[1:0]);
    assign q2 = vedic2(a[1:0], b[3:2]);
    assign q3 = vedic2(a[3:2], b[3:2]);

    // q1 and q2 share weight 4; q0's low two bits pass straight through.
    assign mid    = {1'b0, q1} + {1'b0, q2};
    assign upper  = {q3, q0[3:2]} + {1'b0, mid};
    assign prod_d = {upper, q0[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_q <= 8'h00;
        end else if (ena) begin
            prod_q <= prod_d;
        end
    end

    assign uo_out = prod_q;

`ifdef VEDIC_STATUS_EN
    logic [2:0] flags_d;
    logic [2:0] flags_q;
    logic       valid_q;

    assign flags_d = {^prod_d, |prod_d[7:4], prod_d == 8'h00};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q <= 3'b000;
            valid_q <= 1'b0;
        end else if (ena) begin
            flags_q <= flags_d;
            valid_q <= 1'b1;
        end
    end

    assign uio_out = {4'h0, valid_q, flags_q};
    assign uio_oe  = valid_q ? 8'h0F : 8'h00;
`else
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;
`endif

    // Bidirectional inputs are deliberately ignored.
    logic unused_ok;
    assign unused_ok = ^uio_in;

endmodule

// File: tb/tb_vedic_4x4_multiplier.sv
// Self-checking bench for vedic_4x4_multiplier.
// Reference model is plain a*b with a held-value register.
module tb_vedic_4x4_multiplier;

    logic       clk;
    logic       rst;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int total;
    int bad;

    logic [7:0] exp_p;
    logic       exp_v;

    vedic_4x4_multiplier dut (
        .clk    (clk),
        .rst    (rst),
        .ena    (ena),
        .ui_in  (ui_in),
        .uio_in (uio_in),
        .uo_out (uo_out),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(
        input string      tag,
        input logic [7:0] got,
        input logic [7:0] want
    );
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    function automatic logic [7:0] stat_of(
        input logic [7:0] p,
        input logic       v
    );
`ifdef VEDIC_STATUS_EN
        if (!v) return 8'h00;
        return {4'h0, 1'b1, ^p, p > 8'd15, p == 8'd0};
`else
        return 8'h00 & {p[0], 7'd0} & {8{v}};
`endif
    endfunction

    function automatic logic [7:0] oe_of(input logic v);
`ifdef VEDIC_STATUS_EN
        return v ? 8'h0F : 8'h00;
`else
        return 8'h00 & {8{v}};
`endif
    endfunction

    // Drive operands, take one edge, update model, sample 1 time unit later.
    task automatic step(input logic [3:0] a, input logic [3:0] b);
        ui_in = {b, a};
        @(posedge clk);
        if (ena && !rst) begin
            exp_p = 8'(int'(a) * int'(b));
            exp_v = 1'b1;
        end
        #1;
    endtask

    task automatic check_all(input string tag);
        check({tag, "_prod"}, uo_out, exp_p);
        check({tag, "_stat"}, uio_out, stat_of(exp_p, exp_v));
        check({tag, "_oe"}, uio_oe, oe_of(exp_v));
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        exp_p  = 8'h00;
        exp_v  = 1'b0;
        rst    = 1'b1;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;

        repeat (2) @(posedge clk);
        #1;
        check_all("reset");

        @(negedge clk);
        rst = 1'b0;
        #1;
        check_all("post_release");

        step(4'd3, 4'd5);
        check_all("v3x5");
        check("v3x5_const", uo_out, 8'd15);
        // Operand change mid-cycle must not reach the output.
        ui_in = 8'h72;
        #2;
        check("latency_hold", uo_out, 8'd15);
        step(4'd7, 4'd2);
        check_all("v7x2");
        step(4'd9, 4'd4);
        check_all("v9x4");
        check("v9x4_const", uo_out, 8'd36);

        step(4'd15, 4'd15);
        check_all("max");
        check("max_const", uo_out, 8'd225);

        ena = 1'b0;
        step(4'd3, 4'd3);
        check_all("ena0_a");
        step(4'd3, 4'd3);
        check("ena0_b", uo_out, 8'd225);
        ena = 1'b1;
        step(4'd3, 4'd3);
        check_all("ena1");
        check("ena1_const", uo_out, 8'd9);

        step(4'd0, 4'd9);
        check_all("zero");

        step(4'd15, 4'd15);
        check_all("max2");
        // Asynchronous reset away from any clock edge.
        #3;
        rst = 1'b1;
        #1;
        exp_p = 8'h00;
        exp_v = 1'b0;
        check_all("async_rst");
        step(4'd15, 4'd15);
        check_all("rst_hold");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 256; i++) begin
            step(4'(i), 4'(i >> 4));
            if (uo_out !== exp_p || uio_out !== stat_of(exp_p, exp_v))
                check_all($sformatf("sweep_%0d", i));
            else
                total++;
        end

        for (int i = 0; i < 300; i++) begin
            ena = ($urandom_range(0, 3) != 0);
            uio_in = 8'($urandom);
            step(4'($urandom), 4'($urandom));
            if (uo_out !== exp_p || uio_out !== stat_of(exp_p, exp_v))
                check_all($sformatf("rand_%0d", i));
            else
                total++;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vedic_4x4_multiplier.md
# vedic_4x4_multiplier

Registered 4-bit × 4-bit unsigned multiplier built from Urdhva-Tiryagbhyam (Vedic) 2×2 partial-product cells. It sits as the top-level user block of a TinyTapeout-style tile. Operands come in on the dedicated input byte and the 8-bit product leaves on the dedicated output byte. An optional status nibble can be driven on the bidirectional pins.

## Interface
Parameters:
- none; all widths are fixed (4-bit operands, 8-bit product).

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-high; clears all state immediately.
- ena  input  1  tile enable; when low, registered state holds its value.
- ui_in  input  8  operands: a = ui_in[3:0], b = ui_in[7:4], both unsigned.
- uio_in  input  8  unused; ignored.
- uo_out  output  8  registered product a×b.
- uio_out  output  8  status bits (see Configuration); 0 when the feature is compiled out.
- uio_oe  output  8  bidirectional output enables.

## Operation
- Combinational core: four 2×2 Vedic cells.
  - Cell inputs: a[1:0]×b[1:0], a[3:2]×b[1:0], a[1:0]×b[3:2], a[3:2]×b[3:2].
  - Each cell forms its crosswise products with AND gates and half adders, giving a 4-bit result.
- Cell results are aligned (weights 1, 4, 4, 16) and summed with ripple adders into an exact 8-bit product.
- Width rule: the maximum value is 15×15 = 225, so the 8-bit result never overflows and never truncates.
- The result must equal the unsigned product a×b for all 256 operand combinations.
- On each rising clk with ena=1 and rst=0: uo_out ← a×b of the current ui_in.
- With ena=0: uo_out holds its previous value. The combinational core may still toggle.
- uio_in is never read.

## Timing
- Reset: uo_out = 8'h00, uio_out = 8'h00 and uio_oe = 8'h00 while rst=1, asynchronously. The reset applies mid-operation and regardless of clk.
- Latency: exactly one clock.
  - Operands present before rising edge N appear on uo_out after edge N.
  - The output stays stable until edge N+1.
- Throughput: one new product per clock; there is no handshake.
- Operand changes between edges do not affect uo_out until the next enabled edge.
- Reset release: the first enabled rising edge after rst falls captures the current operands.
- Simultaneous rst=1 and clk edge: reset wins.

## Configuration
- Macro: VEDIC_STATUS_EN.
- Defined: a registered status nibble is captured on the same edge and under the same ena/rst rules as uo_out.
  - uio_out[0] = product == 0.
  - uio_out[1] = product[7:4] != 0 (result exceeds 4 bits).
  - uio_out[2] = XOR-reduction of the product (parity).
  - uio_out[3] = valid: 0 after reset, set to 1 on the first enabled edge, then sticky until reset.
  - uio_out[7:4] = 0.
  - uio_oe = 8'h0F after the first enabled edge; 8'h00 during and immediately after reset.
- Undefined: uio_out = 8'h00 and uio_oe = 8'h00 constantly. The product path is identical in both builds.

## Test plan
- Assert rst with ui_in=0 for 2 cycles -> uo_out=0, uio_out=0, uio_oe=0; with status enabled, valid=0.
- After release, apply ui_in={4'd5,4'd3}, then {4'd2,4'd7}, then {4'd4,4'd9} on consecutive cycles -> uo_out = 15, then 14, then 36, each one cycle after its operands.
- Apply ui_in={4'd15,4'd15} -> uo_out=225; with status enabled, uio_out[1]=1 and parity=0.
- Apply ui_in={4'd9,4'd0} -> uo_out=0; with status enabled, zero flag=1.
- Hold ena=0, then change ui_in to {4'd3,4'd3} -> uo_out keeps its previous value. Raise ena -> uo_out=9 after one edge.
- Assert rst asynchronously mid-cycle while uo_out=225 -> uo_out=0 immediately, without waiting for a clock edge. Then sweep all 256 operand pairs -> each output matches a×b.
